// File: rtl/sm_dma.sv
`default_nettype none
// ============================================================================
//  Module   : sm_dma
//  Brief    : Single-channel memory-to-memory copy engine. Requests the data
//             bus through a req/gnt handshake and copies one 32-bit word per
//             read/write bus pair, in ascending address order.
//  Revision : 1.0  initial release
// ============================================================================
module sm_dma #(
    parameter int CNT_WIDTH = 16,
    parameter int ADDR_STEP = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [31:0]          srcAddr,
    input  logic [31:0]          dstAddr,
    input  logic [CNT_WIDTH-1:0] wordCount,
    output logic                 busy,
    output logic                 done,
    output logic                 bReq,
    input  logic                 bGnt,
    output logic [31:0]          bAddr,
    output logic                 bWrite,
    output logic [31:0]          bWData,
    input  logic [31:0]          bRData
);

    localparam logic [31:0]          c_STEP    = 32'(ADDR_STEP);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [31:0]           r_src;
    logic [31:0]           r_dst;
    logic [31:0]           r_buf;
    logic [CNT_WIDTH-1:0]  r_count;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Command latch, read buffer and address/count advance; a withheld grant
    // leaves every register untouched so a stalled word is never lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_buf   <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src   <= srcAddr;
                        r_dst   <= dstAddr;
                        r_count <= wordCount;
                    end
                end
                S_READ: begin
                    if (bGnt) begin
                        r_buf <= bRData;
                    end
                end
                S_WRITE: begin
                    if (bGnt) begin
                        r_src   <= r_src + c_STEP;
                        r_dst   <= r_dst + c_STEP;
                        r_count <= r_count - c_CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and bus decode; bus outputs are idle-zero outside READ/WRITE
    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        bReq        = 1'b0;
        bAddr       = '0;
        bWrite      = 1'b0;
        bWData      = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = (wordCount != '0) ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                busy  = 1'b1;
                bReq  = 1'b1;
                bAddr = r_src;
                if (bGnt) begin
                    w_nextState = S_WRITE;
                end
            end
            S_WRITE: begin
                busy   = 1'b1;
                bReq   = 1'b1;
                bAddr  = r_dst;
                bWData = r_buf;
                // Write strobe is gated by grant so it never fires unowned
                bWrite = bGnt;
                if (bGnt) begin
                    w_nextState = (r_count == c_CNT_ONE) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sm_dma.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sm_dma
//  Brief    : Self-checking bench for sm_dma. A word-addressed RAM acts as the
//             bus slave; a transaction-queue model predicts every bus cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sm_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] srcAddr;
    logic [31:0] dstAddr;
    logic [15:0] wordCount;
    logic        busy;
    logic        done;
    logic        bReq;
    logic        bGnt;
    logic [31:0] bAddr;
    logic        bWrite;
    logic [31:0] bWData;
    logic [31:0] bRData;

    sm_dma #(.CNT_WIDTH(16), .ADDR_STEP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .srcAddr   (srcAddr),
        .dstAddr   (dstAddr),
        .wordCount (wordCount),
        .busy      (busy),
        .done      (done),
        .bReq      (bReq),
        .bGnt      (bGnt),
        .bAddr     (bAddr),
        .bWrite    (bWrite),
        .bWData    (bWData),
        .bRData    (bRData)
    );

    always #5 clk = ~clk;

    // Bus slave: 1024 words, address bits [11:2], combinational read
    logic [31:0] ram    [0:1023];
    logic [31:0] refMem [0:1023];
    assign bRData = ram[bAddr[11:2]];

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
    } op_t;

    op_t         q[$];
    logic [31:0] pendData = '0;
    bit          doneNow  = 1'b0;
    bit          armed    = 1'b0;
    bit          initMem  = 1'b0;
    bit          randGnt  = 1'b0;
    int          cyc = 0, startCyc = 0, doneCyc = 0;
    int          wrCnt = 0, reqCnt = 0, doneCnt = 0;
    int          total = 0, bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare: expected outputs follow from the pending transaction
    // list; the model then advances on the same inputs the DUT sees.
    task automatic compareCycle();
        bit          expReq;
        logic [31:0] expAddr, expWData;
        logic        expWr;
        bit          doneNext;
        op_t         op;
        if (initMem) begin
            for (int i = 0; i < 1024; i++) begin
                ram[i]    = 32'hC0DE_0000 + 32'(i);
                refMem[i] = 32'hC0DE_0000 + 32'(i);
            end
        end
        if (armed) begin
            expReq   = (q.size() != 0);
            expAddr  = expReq ? q[0].addr : 32'h0;
            expWr    = expReq && q[0].wr && bGnt;
            expWData = (expReq && q[0].wr) ? pendData : 32'h0;
            check("bReq",   {31'b0, bReq},   {31'b0, expReq});
            check("busy",   {31'b0, busy},   {31'b0, expReq});
            check("done",   {31'b0, done},   {31'b0, (!expReq && doneNow)});
            check("bAddr",  bAddr,           expAddr);
            check("bWrite", {31'b0, bWrite}, {31'b0, expWr});
            check("bWData", bWData,          expWData);
            if (bWrite) wrCnt++;
            if (bReq)   reqCnt++;
            if (done) begin
                doneCnt++;
                doneCyc = cyc;
            end
            if (bWrite && bGnt) ram[bAddr[11:2]] = bWData;
            if (rst_n) begin
                doneNext = 1'b0;
                if (q.size() != 0) begin
                    if (bGnt) begin
                        op = q.pop_front();
                        if (!op.wr) begin
                            pendData = refMem[op.addr[11:2]];
                        end else begin
                            refMem[op.addr[11:2]] = pendData;
                            if (q.size() == 0) doneNext = 1'b1;
                        end
                    end
                end else if (!doneNow && start) begin
                    for (int i = 0; i < int'(wordCount); i++) begin
                        q.push_back(op_t'{wr: 1'b0, addr: srcAddr + 32'(4 * i)});
                        q.push_back(op_t'{wr: 1'b1, addr: dstAddr + 32'(4 * i)});
                    end
                    if (wordCount == 16'd0) doneNext = 1'b1;
                end
                doneNow = doneNext;
            end
        end
        if (!rst_n) begin
            q.delete();
            doneNow = 1'b0;
            armed   = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compareCycle();
        @(posedge clk);
        #1;
        cyc++;
        bGnt = randGnt ? ($urandom_range(0, 1) == 1) : 1'b1;
    endtask

    task automatic issue(input logic [31:0] s, input logic [31:0] d, input int n);
        srcAddr   = s;
        dstAddr   = d;
        wordCount = 16'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        startCyc  = cyc;
    endtask

    task automatic waitDone(input string name, input int budget);
        int d0;
        d0 = doneCnt;
        for (int i = 0; i < budget && doneCnt == d0; i++) tick();
        check(name, {31'b0, (doneCnt != d0)}, 32'd1);
    endtask

    initial begin
        int w0, r0, d0, diffs;
        rst_n = 1'b0; start = 1'b0; bGnt = 1'b1;
        srcAddr = '0; dstAddr = '0; wordCount = '0;
        initMem = 1'b1;
        tick();
        tick();
        initMem = 1'b0;
        rst_n   = 1'b1;
        check("reset busy",   {31'b0, busy},   32'd0);
        check("reset done",   {31'b0, done},   32'd0);
        check("reset bReq",   {31'b0, bReq},   32'd0);
        check("reset bWrite", {31'b0, bWrite}, 32'd0);
        check("reset bAddr",  bAddr,           32'd0);
        check("reset bWData", bWData,          32'd0);
        tick();

        // 4-word copy, grant held
        w0 = wrCnt;
        issue(32'h100, 32'h200, 4);
        waitDone("copy4 done", 40);
        check("copy4 latency", 32'(doneCyc - startCyc), 32'd8);
        check("copy4 writes",  32'(wrCnt - w0), 32'd4);
        check("copy4 w0", ram[128], 32'hC0DE_0040);
        check("copy4 w1", ram[129], 32'hC0DE_0041);
        check("copy4 w2", ram[130], 32'hC0DE_0042);
        check("copy4 w3", ram[131], 32'hC0DE_0043);
        tick();

        // Zero-length command, plus a start landing on the DONE cycle
        r0 = reqCnt; d0 = doneCnt;
        issue(32'h100, 32'h500, 0);
        srcAddr = 32'h100; dstAddr = 32'h540; wordCount = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        check("zero latency", 32'(doneCyc - startCyc), 32'd0);
        repeat (6) tick();
        check("zero reqs",  32'(reqCnt - r0),  32'd0);
        check("zero dones", 32'(doneCnt - d0), 32'd1);
        check("zero dst",   ram[320], 32'hC0DE_0140);
        check("ignored dst", ram[336], 32'hC0DE_0150);

        // 3-word copy under a random grant pattern
        randGnt = 1'b1;
        w0 = wrCnt;
        issue(32'h140, 32'h280, 3);
        waitDone("rand done", 200);
        randGnt = 1'b0;
        tick();
        check("rand writes", 32'(wrCnt - w0), 32'd3);
        check("rand w0", ram[160], 32'hC0DE_0050);
        check("rand w2", ram[162], 32'hC0DE_0052);

        // Source address wraps past the top of the address space
        issue(32'hFFFF_FFFC, 32'h300, 2);
        waitDone("wrap done", 40);
        check("wrap w0", ram[192], 32'hC0DE_03FF);
        check("wrap w1", ram[193], 32'hC0DE_0000);
        tick();

        // Second start while busy must be ignored
        d0 = doneCnt;
        issue(32'h100, 32'h380, 3);
        tick();
        srcAddr = 32'h140; dstAddr = 32'h3C0; wordCount = 16'd5; start = 1'b1;
        tick();
        start = 1'b0;
        waitDone("busy-start done", 40);
        repeat (4) tick();
        check("busy-start dones", 32'(doneCnt - d0), 32'd1);
        check("busy-start w2", ram[226], 32'hC0DE_0042);
        check("busy-start ign", ram[240], 32'hC0DE_00F0);

        // Reset after the second word of an 8-word copy
        d0 = doneCnt;
        issue(32'h100, 32'h400, 8);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst busy",  {31'b0, busy}, 32'd0);
        check("midrst bReq",  {31'b0, bReq}, 32'd0);
        check("midrst bAddr", bAddr,         32'd0);
        repeat (5) tick();
        check("midrst dones", 32'(doneCnt - d0), 32'd0);
        check("midrst w0", ram[256], 32'hC0DE_0040);
        check("midrst w1", ram[257], 32'hC0DE_0041);
        check("midrst w2", ram[258], 32'hC0DE_0102);
        issue(32'h100, 32'h440, 2);
        waitDone("post-rst done", 40);
        check("post-rst w1", ram[273], 32'hC0DE_0041);
        tick();

        diffs = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== refMem[i]) diffs++;
        check("ram vs model", 32'(diffs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sm_dma.md
Name: sm_dma

Overview:
- Single-channel memory-to-memory copy engine and bus initiator for the schoolMIPS data bus.
- Drives the same address/write/data/read-data bus the CPU drives into the bus matrix, so the matrix decodes and routes its accesses exactly like CPU accesses.
- Copies a block of 32-bit words from a source to a destination region, one word per read/write pair.
- Requests the bus from an external arbiter with a req/gnt handshake.

Parameters:
- CNT_WIDTH, 16, width of the word-count input and internal remaining-count register.
- ADDR_STEP, 4, byte increment applied to source and destination addresses after each word.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle command strobe; sampled only in IDLE.
- srcAddr  input  32  source byte address, latched on accepted start.
- dstAddr  input  32  destination byte address, latched on accepted start.
- wordCount  input  CNT_WIDTH  number of words to copy, latched on accepted start.
- busy  output  1  high while in READ or WRITE.
- done  output  1  one-cycle pulse when the transfer completes.
- bReq  output  1  bus request to arbiter.
- bGnt  input  1  bus grant; the bus is owned in any cycle where bReq & bGnt.
- bAddr  output  32  bus address.
- bWrite  output  1  bus write enable.
- bWData  output  32  bus write data.
- bRData  input  32  bus read data; combinational from the addressed slave in the same cycle.

Behaviour:
- Synchronous active-low reset, taking effect at the next rising edge of clk while rst_n=0.
- Reset values:
  - state = IDLE.
  - busy = 0, done = 0, bReq = 0, bWrite = 0.
  - bAddr = 0, bWData = 0.
  - Internal src, dst, count and data buffer registers = 0.
- State IDLE:
  - All bus outputs are at their reset values.
  - On start=1 at an edge, latch src, dst and count.
  - Next state is READ if wordCount != 0, else DONE.
- State READ:
  - bReq=1, bAddr=src, bWrite=0.
  - At an edge with bGnt=1: buffer <= bRData, state -> WRITE.
  - With bGnt=0: hold state and all registers.
- State WRITE:
  - bReq=1, bAddr=dst, bWData=buffer, bWrite=bGnt (never asserted without grant).
  - At an edge with bGnt=1:
    - src <= src+ADDR_STEP, dst <= dst+ADDR_STEP, count <= count-1.
    - Next state is DONE if count==1, else READ.
  - With bGnt=0: hold.
- State DONE:
  - done=1, busy=0, bReq=0 for exactly one cycle.
  - Next state is IDLE unconditionally.
- Decode rule: bAddr, bWData and bWrite are combinational from state and registers; bWrite additionally depends on bGnt. In IDLE/DONE, bAddr=0, bWData=0, bWrite=0.
- Timing with bGnt held at 1 and start accepted at edge k:
  - Word i is read in cycle k+1+2i and written in cycle k+2+2i.
  - done is high in cycle k+1+2N.
  - Throughput is one word per 2 cycles.
- Boundary conditions:
  - wordCount=0: done pulses in cycle k+1; no bus request and no bus access.
  - start while not IDLE: ignored; latched registers unchanged.
  - start coincident with the DONE cycle: ignored, since the state is not IDLE.
  - Address overflow: src and dst wrap modulo 2^32 (0xFFFFFFFC+4=0x00000000); no error is raised.
  - Overlapping regions: copy proceeds in ascending address order; no overlap check.
  - bGnt withdrawn mid-transfer: the engine stalls in its current state with no lost or duplicated word; the buffer is retained across the stall.
  - Reset mid-transfer: return to IDLE at the edge with rst_n=0; any partial copy is left as-is; no done pulse.
  - Maximum count 2^CNT_WIDTH-1 is supported; the count never underflows.

Test Plan:
- RAM preloaded 0x100..0x10C = A0,A1,A2,A3; srcAddr=0x100, dstAddr=0x200, wordCount=4, bGnt=1 -> RAM 0x200..0x20C = A0..A3; done high exactly 9 cycles after the start edge; bWrite high 4 cycles total.
- wordCount=0, start=1 -> done pulses the next cycle; bReq and bWrite never assert; RAM unchanged.
- Copy of 3 words with bGnt toggled by a random 50% pattern -> destination data is correct; bWrite=1 only in cycles with bGnt=1; exactly 3 write cycles.
- srcAddr=0xFFFFFFFC, wordCount=2 -> second read address is 0x00000000, and the destination increments likewise.
- start pulsed again during busy with different addresses -> the second command is ignored; only the first copy is performed; one done pulse.
- rst_n=0 for 1 cycle after the 2nd word write of an 8-word copy -> outputs return to reset values the next cycle; only 2 destination words are modified; no done pulse; a subsequent new start completes normally.
